// File: rtl/exe_mem_stage.sv
// Execute stage with forwarding, single-cycle ALU and a 32-cycle shift-add multiplier.
// Includes the execute-to-memory pipeline register and the upstream stall request.
module exe_mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] RD1E,
    input  logic [31:0] RD2E,
    input  logic [31:0] immExtE,
    input  logic [3:0]  WA3E,
    input  logic        aluSrcE,
    input  logic [2:0]  aluCtrlE,
    input  logic        regWriteE,
    input  logic        memWriteE,
    input  logic        memToRegE,
    input  logic [1:0]  fwdAE,
    input  logic [1:0]  fwdBE,
    input  logic [31:0] resultW,
    output logic        stallE,
    output logic [31:0] aluResultM,
    output logic [31:0] writeDataM,
    output logic [3:0]  WA3M,
    output logic        regWriteM,
    output logic        memWriteM,
    output logic        memToRegM,
    output logic [3:0]  flagsM
);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t      state;
    logic [31:0] src_a;
    logic [31:0] fwd_b;
    logic [31:0] src_b;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [31:0] acc;
    logic [4:0]  count;
    logic [32:0] sum;
    logic [31:0] result;
    logic        carry;
    logic        overflow;

    always_comb begin
        case (fwdAE)
            2'b01:   src_a = resultW;
            2'b10:   src_a = aluResultM;
            default: src_a = RD1E;
        endcase
        case (fwdBE)
            2'b01:   fwd_b = resultW;
            2'b10:   fwd_b = aluResultM;
            default: fwd_b = RD2E;
        endcase
        src_b = aluSrcE ? immExtE : fwd_b;
    end

    always_comb begin
        sum      = '0;
        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (aluCtrlE)
            3'b000: begin
                sum      = {1'b0, src_a} + {1'b0, src_b};
                result   = sum[31:0];
                carry    = sum[32];
                overflow = (src_a[31] == src_b[31]) && (result[31] != src_a[31]);
            end
            3'b001: begin
                sum      = {1'b0, src_a} + {1'b0, ~src_b} + 33'd1;
                result   = sum[31:0];
                carry    = sum[32];
                overflow = (src_a[31] != src_b[31]) && (result[31] != src_a[31]);
            end
            3'b010:  result = src_a & src_b;
            3'b011:  result = src_a | src_b;
            3'b100:  result = src_a ^ src_b;
            3'b101:  result = src_a << src_b[4:0];
            3'b110:  result = src_a >> src_b[4:0];
            // Only consumed in DONE; earlier mul cycles load a bubble instead.
            default: result = acc;
        endcase
    end

    // Gated by rst so the stall drops as soon as reset asserts, even with a mul still presented.
    assign stallE = !rst && (((state == IDLE) && (aluCtrlE == 3'b111)) || (state == MUL));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            count  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (aluCtrlE == 3'b111) begin
                        mcand  <= src_b;
                        mplier <= src_a;
                        acc    <= '0;
                        count  <= '0;
                        state  <= MUL;
                    end
                end
                MUL: begin
                    if (mcand[0])
                        acc <= acc + mplier;
                    mplier <= mplier << 1;
                    mcand  <= mcand >> 1;
                    count  <= count + 5'd1;
                    if (count == 5'd31)
                        state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || stallE) begin
            aluResultM <= '0;
            writeDataM <= '0;
            WA3M       <= '0;
            regWriteM  <= 1'b0;
            memWriteM  <= 1'b0;
            memToRegM  <= 1'b0;
            flagsM     <= '0;
        end else begin
            aluResultM <= result;
            writeDataM <= fwd_b;
            WA3M       <= WA3E;
            regWriteM  <= regWriteE;
            memWriteM  <= memWriteE;
            memToRegM  <= memToRegE;
            flagsM     <= {result[31], (result == 32'd0), carry, overflow};
        end
    end

endmodule

// File: tb/tb_exe_mem_stage.sv
// Scoreboard bench for exe_mem_stage: a driver pushes expected M-register contents per cycle,
// a monitor pops and compares them after every clock edge.
module tb_exe_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] RD1E, RD2E, immExtE, resultW;
    logic [3:0]  WA3E;
    logic        aluSrcE;
    logic [2:0]  aluCtrlE;
    logic        regWriteE, memWriteE, memToRegE;
    logic [1:0]  fwdAE, fwdBE;
    logic        stallE;
    logic [31:0] aluResultM, writeDataM;
    logic [3:0]  WA3M;
    logic        regWriteM, memWriteM, memToRegM;
    logic [3:0]  flagsM;

    exe_mem_stage dut (
        .clk(clk), .rst(rst), .RD1E(RD1E), .RD2E(RD2E), .immExtE(immExtE), .WA3E(WA3E),
        .aluSrcE(aluSrcE), .aluCtrlE(aluCtrlE), .regWriteE(regWriteE), .memWriteE(memWriteE),
        .memToRegE(memToRegE), .fwdAE(fwdAE), .fwdBE(fwdBE), .resultW(resultW),
        .stallE(stallE), .aluResultM(aluResultM), .writeDataM(writeDataM), .WA3M(WA3M),
        .regWriteM(regWriteM), .memWriteM(memWriteM), .memToRegM(memToRegM), .flagsM(flagsM)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [31:0] wd;
        logic        chk_wd;
        logic [3:0]  wa;
        logic        rw, mw, mr;
        logic [3:0]  flags;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          fails  = 0;
    logic [31:0] model_m = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] regval,
                                        input logic [31:0] wb);
        if (sel == 2'b01)      return wb;
        else if (sel == 2'b10) return model_m;
        else                   return regval;
    endfunction

    // Arithmetic reference: carries from 64-bit sums, overflow from true signed results.
    function automatic void ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic [3:0] f);
        longint unsigned wa, wb, wide;
        longint          sa, sb, sr;
        logic            c, v;
        logic [4:0]      sh;
        wa = a; wb = b;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = b[4:0];
        c = 1'b0; v = 1'b0; r = '0;
        case (op)
            3'd0: begin
                wide = wa + wb; r = wide[31:0]; c = wide[32];
                sr = sa + sb; v = (sr != longint'($signed(r)));
            end
            3'd1: begin
                r = a - b; c = (a >= b);
                sr = sa - sb; v = (sr != longint'($signed(r)));
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = a << sh;
            3'd6: r = a >> sh;
            default: begin wide = wa * wb; r = wide[31:0]; end
        endcase
        f = {r[31], (r == 32'd0), c, v};
    endfunction

    function automatic exp_t bubble();
        exp_t e;
        e.res = '0; e.wd = '0; e.chk_wd = 1'b0; e.wa = '0;
        e.rw = 1'b0; e.mw = 1'b0; e.mr = 1'b0; e.flags = '0;
        return e;
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] rd1, input logic [31:0] rd2,
                         input logic [31:0] imm, input logic src, input logic [1:0] fa,
                         input logic [1:0] fb, input logic [31:0] wb, input logic [3:0] wa,
                         input logic rw, input logic mw, input logic mr);
        logic [31:0] a, bf, b, r;
        logic [3:0]  f;
        exp_t        e;
        @(negedge clk);
        RD1E = rd1; RD2E = rd2; immExtE = imm; aluSrcE = src; fwdAE = fa; fwdBE = fb;
        resultW = wb; WA3E = wa; regWriteE = rw; memWriteE = mw; memToRegE = mr; aluCtrlE = op;
        a  = fwd(fa, rd1, wb);
        bf = fwd(fb, rd2, wb);
        b  = src ? imm : bf;
        ref_alu(op, a, b, r, f);
        if (op == 3'd7) begin
            for (int k = 0; k < 33; k++) begin
                if (k > 0) @(negedge clk);
                #1;
                check("stall_mul", 32'(stallE), 32'd1);
                sbq.push_back(bubble());
                model_m = '0;
            end
            @(negedge clk);
            bf = fwd(fb, rd2, wb);
        end
        #1;
        check("stall_done", 32'(stallE), 32'd0);
        e.res = r; e.wd = bf; e.chk_wd = 1'b1; e.wa = wa;
        e.rw = rw; e.mw = mw; e.mr = mr; e.flags = f;
        sbq.push_back(e);
        model_m = r;
    endtask

    task automatic expect_now(input string name, input logic [31:0] res, input logic [3:0] flags);
        @(posedge clk);
        #2;
        check({name, "_res"}, aluResultM, res);
        check({name, "_flags"}, 32'(flagsM), 32'(flags));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("sb_result", aluResultM, e.res);
                if (e.chk_wd) check("sb_wdata", writeDataM, e.wd);
                check("sb_wa3", 32'(WA3M), 32'(e.wa));
                check("sb_ctrl", 32'({regWriteM, memWriteM, memToRegM}), 32'({e.rw, e.mw, e.mr}));
                check("sb_flags", 32'(flagsM), 32'(e.flags));
            end
        end
    end

    initial begin : driver
        logic [2:0]  op;
        logic [1:0]  fa, fb;
        rst = 1'b1;
        RD1E = '0; RD2E = '0; immExtE = '0; resultW = '0; WA3E = '0; aluSrcE = 1'b0;
        aluCtrlE = 3'd0; regWriteE = 1'b0; memWriteE = 1'b0; memToRegE = 1'b0;
        fwdAE = '0; fwdBE = '0;
        repeat (2) @(negedge clk);
        check("rst_stall", 32'(stallE), 32'd0);
        check("rst_result", aluResultM, 32'd0);
        check("rst_wdata", writeDataM, 32'd0);
        check("rst_misc", 32'({WA3M, regWriteM, memWriteM, memToRegM, flagsM}), 32'd0);
        rst = 1'b0;

        issue(3'd0, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 4'd1, 1'b1, 1'b0, 1'b0);
        expect_now("add_ovf", 32'h8000_0000, 4'b1001);
        issue(3'd1, 32'd5, 32'd5, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 4'd2, 1'b1, 1'b0, 1'b0);
        expect_now("sub_eq", 32'd0, 4'b0110);
        issue(3'd1, 32'd3, 32'd5, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 4'd3, 1'b1, 1'b0, 1'b0);
        expect_now("sub_borrow", 32'hFFFF_FFFE, 4'b1000);

        issue(3'd0, 32'h10, 32'd0, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 4'd4, 1'b1, 1'b0, 1'b0);
        issue(3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 2'b10, 2'b01, 32'h20, 4'd5, 1'b1, 1'b0, 1'b0);
        expect_now("fwd_add", 32'h30, 4'b0000);
        check("fwd_wdata", writeDataM, 32'h20);

        issue(3'd5, 32'd1, 32'hAA, 32'h24, 1'b1, 2'b00, 2'b00, 32'd0, 4'd6, 1'b0, 1'b1, 1'b0);
        expect_now("lsl_imm", 32'h10, 4'b0000);
        check("lsl_wdata", writeDataM, 32'hAA);
        issue(3'd6, 32'h8000_0001, 32'd0, 32'h20, 1'b1, 2'b00, 2'b00, 32'd0, 4'd6, 1'b1, 1'b0, 1'b0);
        expect_now("lsr_zero", 32'h8000_0001, 4'b1000);

        issue(3'd7, 32'h0001_2345, 32'h0001_0000, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 4'd7, 1'b1, 1'b0, 1'b0);
        expect_now("mul1", 32'h2345_0000, 4'b0000);
        check("mul1_wa3", 32'(WA3M), 32'd7);
        check("mul1_rw", 32'(regWriteM), 32'd1);
        issue(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 4'd8, 1'b1, 1'b0, 1'b0);
        expect_now("mul2", 32'h0000_0001, 4'b0000);

        // Reset during the tenth MUL cycle.
        @(negedge clk);
        RD1E = 32'h1234; RD2E = 32'h5678; aluSrcE = 1'b0; fwdAE = '0; fwdBE = '0;
        WA3E = 4'd9; regWriteE = 1'b1; aluCtrlE = 3'd7;
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            check("stall_pre_rst", 32'(stallE), 32'd1);
            sbq.push_back(bubble());
        end
        #1;
        rst = 1'b1;
        #1;
        check("rst_async_stall", 32'(stallE), 32'd0);
        check("rst_async_out", aluResultM | writeDataM, 32'd0);
        check("rst_async_misc", 32'({WA3M, regWriteM, memWriteM, memToRegM, flagsM}), 32'd0);
        aluCtrlE = 3'd0;
        repeat (2) @(negedge clk);
        sbq.delete();
        model_m = '0;
        rst = 1'b0;
        issue(3'd0, 32'd40, 32'd2, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 4'd3, 1'b1, 1'b0, 1'b0);
        expect_now("post_rst_add", 32'd42, 4'b0000);

        for (int i = 0; i < 300; i++) begin
            op = ($urandom_range(0, 19) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
            fa = 2'($urandom_range(0, 3));
            fb = 2'($urandom_range(0, 3));
            if (op == 3'd7 && fb == 2'b10) fb = 2'b01;
            issue(op, $urandom(), $urandom(), $urandom(), 1'($urandom_range(0, 1)), fa, fb,
                  $urandom(), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(sbq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
